// File: rtl/requant_round_sat_pkg.sv
// Shared types and default widths for the requantiser slice.
package requant_round_sat_pkg;

  typedef enum logic [1:0] {
    RM_HALF_AWAY = 2'd0,
    RM_TRUNC     = 2'd1,
    RM_HALF_EVEN = 2'd2,
    RM_FLOOR     = 2'd3
  } round_mode_e;

  localparam int DEF_IN_W  = 50;
  localparam int DEF_OUT_W = 31;
  localparam int DEF_SH_W  = 6;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/requant_round_sat_stage_ctl.sv
// One pipeline stage's occupancy bit: loads when empty or when the next stage drains it.
module pipe_stage_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_next_ready,
  output logic o_valid,
  output logic o_ready,
  output logic o_load
);

  logic r_valid;

  assign o_valid = r_valid;
  assign o_ready = !r_valid || i_next_ready;
  assign o_load  = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
    end
  end

endmodule

// File: rtl/requant_round_sat.sv
// Three-stage requantiser: divide by 2^shift with selectable rounding, then saturate to OUT_W.
module requant_round_sat
  import requant_round_sat_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SH_W  = DEF_SH_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic        [SH_W-1:0]  shift_amt,
  input  logic        [1:0]       round_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic        [CNT_W-1:0] sat_count,
  input  logic                    sat_clr
);

  // Handshake: a beat moves on a rising edge when valid && ready; each stage is
  // ready when empty or when its successor takes its contents in that cycle.
  localparam logic [SH_W-1:0]  SH_MAX  = SH_W'(IN_W - 1);
  localparam logic [IN_W:0]    ONE_W   = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0]    NEG_LIM = ONE_W << (OUT_W - 1);
  localparam logic [IN_W:0]    POS_LIM = NEG_LIM - ONE_W;
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic w_v1, w_v2, w_v3;
  logic w_rdy1, w_rdy2, w_rdy3;
  logic w_ld1, w_ld2, w_ld3;

  pipe_stage_ctl u_st1 (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .i_next_ready(w_rdy2),
    .o_valid(w_v1), .o_ready(w_rdy1), .o_load(w_ld1)
  );
  pipe_stage_ctl u_st2 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_v1), .i_next_ready(w_rdy3),
    .o_valid(w_v2), .o_ready(w_rdy2), .o_load(w_ld2)
  );
  pipe_stage_ctl u_st3 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_v2), .i_next_ready(out_ready),
    .o_valid(w_v3), .o_ready(w_rdy3), .o_load(w_ld3)
  );

  assign in_ready  = w_rdy1;
  assign out_valid = w_v3;

  // Stage 1: sign/magnitude split; the unsigned negate maps the most negative input cleanly.
  logic [IN_W-1:0] w_in_u;
  logic [IN_W-1:0] w_mag;
  logic [SH_W-1:0] w_sh;

  assign w_in_u = in_data;
  assign w_mag  = w_in_u[IN_W-1] ? (-w_in_u) : w_in_u;
  assign w_sh   = (shift_amt > SH_MAX) ? SH_MAX : shift_amt;

  logic            r1_s;
  logic [IN_W-1:0] r1_mag;
  logic [SH_W-1:0] r1_sh;
  round_mode_e     r1_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_s    <= 1'b0;
      r1_mag  <= '0;
      r1_sh   <= '0;
      r1_mode <= RM_HALF_AWAY;
    end else if (w_ld1) begin
      r1_s    <= w_in_u[IN_W-1];
      r1_mag  <= w_mag;
      r1_sh   <= w_sh;
      r1_mode <= round_mode_e'(round_mode);
    end
  end

  // Stage 2: quotient plus round/sticky bits; a zero shift yields empty masks.
  logic [IN_W-1:0] w_q;
  logic [IN_W-1:0] w_low_mask;
  logic [IN_W-1:0] w_stk_mask;
  logic            w_rnd;
  logic            w_stk;

  assign w_q        = r1_mag >> r1_sh;
  assign w_low_mask = ~({IN_W{1'b1}} << r1_sh);
  assign w_stk_mask = w_low_mask >> 1;
  assign w_rnd      = |(r1_mag & w_low_mask & ~w_stk_mask);
  assign w_stk      = |(r1_mag & w_stk_mask);

  logic            r2_s;
  logic [IN_W-1:0] r2_q;
  logic            r2_rnd;
  logic            r2_stk;
  round_mode_e     r2_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_s    <= 1'b0;
      r2_q    <= '0;
      r2_rnd  <= 1'b0;
      r2_stk  <= 1'b0;
      r2_mode <= RM_HALF_AWAY;
    end else if (w_ld2) begin
      r2_s    <= r1_s;
      r2_q    <= w_q;
      r2_rnd  <= w_rnd;
      r2_stk  <= w_stk;
      r2_mode <= r1_mode;
    end
  end

  // Stage 3: rounding increment, then clamp against the asymmetric signed range.
  logic             w_inc;
  logic [IN_W:0]    w_m;
  logic [OUT_W-1:0] w_res;
  logic             w_sat;

  always_comb begin
    w_inc = 1'b0;
    case (r2_mode)
      RM_HALF_AWAY: w_inc = r2_rnd;
      RM_TRUNC:     w_inc = 1'b0;
      RM_HALF_EVEN: w_inc = r2_rnd & (r2_stk | r2_q[0]);
      RM_FLOOR:     w_inc = r2_s & (r2_rnd | r2_stk);
      default:      w_inc = 1'b0;
    endcase
  end

  assign w_m = {1'b0, r2_q} + {{IN_W{1'b0}}, w_inc};

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    if (!r2_s && (w_m > POS_LIM)) begin
      w_res = OUT_MAX;
      w_sat = 1'b1;
    end else if (r2_s && (w_m > NEG_LIM)) begin
      w_res = OUT_MIN;
      w_sat = 1'b1;
    end else if (r2_s) begin
      w_res = OUT_W'(-w_m);
    end else begin
      w_res = OUT_W'(w_m);
    end
  end

  logic [OUT_W-1:0] r3_data;
  logic             r3_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_data <= '0;
      r3_sat  <= 1'b0;
    end else if (w_ld3) begin
      r3_data <= w_res;
      r3_sat  <= w_sat;
    end
  end

  assign out_data = r3_data;
  assign out_sat  = r3_sat;

  logic [CNT_W-1:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_v3 && out_ready && r3_sat && !(&r_sat_cnt)) begin
      r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_requant_round_sat.sv
// Directed scoreboard bench for requant_round_sat: driver pushes expected beats, monitor pops on output transfers.
module tb_requant_round_sat;

  localparam int IN_W  = 50;
  localparam int OUT_W = 31;
  localparam int SH_W  = 6;
  localparam int CNT_W = 16;

  localparam logic signed [IN_W-1:0] P40 = 50'sh100_0000_0000;
  localparam logic signed [IN_W-1:0] N49 = 50'sh2_0000_0000_0000;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic        [SH_W-1:0]  shift_amt;
  logic        [1:0]       round_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic        [CNT_W-1:0] sat_count;
  logic                    sat_clr;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [OUT_W:0] exp_q[$];
  int             pop_cyc[$];

  requant_round_sat #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_amt(shift_amt), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  // Clock/reset and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = toggling.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver: must be called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic signed [IN_W-1:0] d, input int sh, input int md,
                      input longint e, input logic es);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_data    = d;
    shift_amt  = SH_W'(sh);
    round_mode = 2'(md);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      acc_cnt++;
      exp_q.push_back({es, OUT_W'(e)});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: scoreboard pop on each output transfer, plus hold-stability during stalls.
  logic [OUT_W:0] held;
  logic           hold_pend;
  logic [OUT_W:0] mon_e;

  initial begin
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          checks++;
          if (!out_valid || ({out_sat, out_data} !== held)) begin
            errors++;
            $display("FAIL hold: got valid=%0b data=%0d sat=%0b, expected valid=1 data=%0d sat=%0b",
                     out_valid, out_data, out_sat, $signed(held[OUT_W-1:0]), held[OUT_W]);
          end
        end
        hold_pend = out_valid && !out_ready;
        held      = {out_sat, out_data};
        if (out_valid && out_ready) begin
          checks++;
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%0d sat=%0b, expected no beat", out_data, out_sat);
          end else begin
            mon_e = exp_q.pop_front();
            if ({out_sat, out_data} !== mon_e) begin
              errors++;
              $display("FAIL out_beat: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                       out_data, out_sat, $signed(mon_e[OUT_W-1:0]), mon_e[OUT_W]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [39:0] m40;
    logic        sg;
    longint      mq;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    shift_amt  = '0;
    round_mode = '0;
    sat_clr    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Legacy 2^20 half-away equivalence.
    send(1572864, 20, 0, 2, 0);
    send(-1572864, 20, 0, -2, 0);
    send(1572863, 20, 0, 1, 0);
    send(524288, 20, 0, 1, 0);
    send(524287, 20, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      m40 = {8'($urandom), 32'($urandom)};
      sg  = 1'($urandom_range(1, 0));
      mq  = (longint'(m40) + 524288) >>> 20;
      send(sg ? -IN_W'(m40) : IN_W'(m40), 20, 0, sg ? -mq : mq, 0);
    end
    drain();

    // Rounding modes.
    send(2621440, 20, 2, 2, 0);
    send(3670016, 20, 2, 4, 0);
    send(-2621440, 20, 2, -2, 0);
    send(-1, 20, 3, -1, 0);
    send(-1048576, 20, 3, -1, 0);
    send(1048575, 20, 3, 0, 0);
    send(-1572864, 20, 1, -1, 0);
    drain();

    // Saturation and shift clamp.
    send(P40, 0, 0, 1073741823, 1);
    send(N49, 0, 0, -1073741824, 1);
    send(-1073741824, 0, 0, -1073741824, 0);
    send(N49, 63, 0, -1, 0);
    drain();
    chk("sat_count_two", sat_count, 2);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("sat_count_clr", sat_count, 0);

    // Backpressure with toggling ready.
    rdy_mode = 1;
    acc_cnt  = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 1; i <= 6; i++) send(i, 0, 0, i, 0);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_accepted", acc_cnt, 3);
        rdy_mode = 2;
      end
    join
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // Per-beat mode switch, back to back.
    pop_cyc.delete();
    for (int md = 0; md < 4; md++) send(2621440, 20, md, (md == 0) ? 3 : 2, 0);
    drain();
    chk("mode_sw_beats", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) chk("mode_sw_span", pop_cyc[3] - pop_cyc[0], 3);

    // Build sat_count to 5, then reset with beats in flight.
    for (int i = 0; i < 5; i++) send(P40, 0, 0, 1073741823, 1);
    drain();
    chk("sat_count_five", sat_count, 5);
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    send(7, 0, 0, 7, 0);
    send(8, 0, 0, 8, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sat_count", sat_count, 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    send(9, 0, 0, 9, 0);
    drain();
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
